// File: rtl/harmonic_capture_pkg.sv
// Shared types and helpers for the harmonic peak capture block.
// Default geometry plus the centre-bin arithmetic used by the top and the bench.
package harmonic_capture_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    PUBLISH = 2'd2
  } state_t;

  localparam int DEF_DW     = 24;
  localparam int DEF_NUM_H  = 5;
  localparam int DEF_BIN0   = 24;
  localparam int DEF_STRIDE = 48;
  localparam int DEF_WIN    = 2;
  localparam int DEF_CNT_W  = 10;

  function automatic int centre_bin(input int h, input int bin0, input int stride);
    return bin0 + h * stride;
  endfunction

  // Highest bin any window looks at; the frame is complete once it is accepted.
  function automatic int last_bin(input int num_h, input int bin0, input int stride,
                                  input int win);
    return centre_bin(num_h - 1, bin0, stride) + win;
  endfunction

endpackage

// File: rtl/harm_window_peak.sv
// Compare-and-hold peak tracker for one harmonic window [lo, hi].
// clear restarts tracking and still evaluates the sample presented with it.
module harm_window_peak
  import harmonic_capture_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] bin,
  input  logic [DW-1:0]    amp,
  input  logic             valid,
  input  logic             clear,
  input  logic [CNT_W-1:0] lo,
  input  logic [CNT_W-1:0] hi,
  output logic [DW-1:0]    max_amp,
  output logic [CNT_W-1:0] max_idx
);

  logic seen_reg;
  logic hit;
  logic take;

  assign hit  = valid && (bin >= lo) && (bin <= hi);
  // Strict compare keeps the earliest of equal peaks.
  assign take = hit && (!seen_reg || (amp > max_amp));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seen_reg <= 1'b0;
      max_amp  <= '0;
      max_idx  <= '0;
    end else if (clear) begin
      seen_reg <= hit;
      max_amp  <= hit ? amp : '0;
      max_idx  <= hit ? bin : '0;
    end else if (take) begin
      seen_reg <= 1'b1;
      max_amp  <= amp;
      max_idx  <= bin;
    end
  end

endmodule

// File: rtl/harmonic_capture.sv
// Per-frame peak search around NUM_H harmonic centre bins of an FFT magnitude stream.
// All results are published together with a single-cycle done pulse.
module harmonic_capture
  import harmonic_capture_pkg::*;
#(
  parameter int DW     = DEF_DW,
  parameter int NUM_H  = DEF_NUM_H,
  parameter int BIN0   = DEF_BIN0,
  parameter int STRIDE = DEF_STRIDE,
  parameter int WIN    = DEF_WIN,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   source_sop,
  input  logic                   source_valid,
  input  logic [DW-1:0]          amp,
  output logic [NUM_H*DW-1:0]    amp_bus,
  output logic [NUM_H*CNT_W-1:0] idx_bus,
  output logic                   done,
  output logic                   busy
);

  localparam int LAST_BIN = last_bin(NUM_H, BIN0, STRIDE, WIN);
  localparam bit NUM_H_OK  = (NUM_H >= 1) && (NUM_H <= 16);
  localparam bit BIN0_OK   = (WIN >= 0) && (BIN0 >= WIN);
  localparam bit STRIDE_OK = (STRIDE > 2 * WIN);
  localparam bit FIT_OK    = (CNT_W < 31) && (LAST_BIN < (1 << CNT_W));

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LAST_BIN);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  if (!(NUM_H_OK && BIN0_OK && STRIDE_OK && FIT_OK)) begin : g_bad_params
    $error("harmonic_capture: inconsistent window geometry parameters");
  end

  state_t                   state_reg;
  state_t                   state_next;
  logic [CNT_W-1:0]         bin_cnt_reg;
  logic [CNT_W-1:0]         cur_bin;
  logic                     start;
  logic                     in_frame;
  logic                     last_hit;
  logic [NUM_H*DW-1:0]      shadow_amp;
  logic [NUM_H*CNT_W-1:0]   shadow_idx;
  logic [NUM_H*DW-1:0]      amp_hold_reg;
  logic [NUM_H*CNT_W-1:0]   idx_hold_reg;

  // A valid sop restarts the frame from any state; its sample is bin 0.
  assign start    = source_valid & source_sop;
  assign cur_bin  = start ? '0 : bin_cnt_reg;
  assign in_frame = source_valid & (start | (state_reg == CAPTURE));
  assign last_hit = in_frame & (cur_bin == LAST_IDX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE:    if (start) state_next = CAPTURE;
      CAPTURE: busy = 1'b1;
      PUBLISH: begin
        done       = 1'b1;
        state_next = start ? CAPTURE : IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (last_hit) state_next = PUBLISH;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bin_cnt_reg <= '0;
    end else if (start) begin
      bin_cnt_reg <= CNT_W'(1);
    end else if (in_frame && (bin_cnt_reg != CNT_MAX)) begin
      bin_cnt_reg <= bin_cnt_reg + CNT_W'(1);
    end
  end

  for (genvar gi = 0; gi < NUM_H; gi++) begin : g_win
    localparam int C = centre_bin(gi, BIN0, STRIDE);
    localparam logic [CNT_W-1:0] LO = CNT_W'(C - WIN);
    localparam logic [CNT_W-1:0] HI = CNT_W'(C + WIN);

    harm_window_peak #(
      .DW    (DW),
      .CNT_W (CNT_W)
    ) u_peak (
      .clk     (clk),
      .rst_n   (rst_n),
      .bin     (cur_bin),
      .amp     (amp),
      .valid   (in_frame),
      .clear   (start),
      .lo      (LO),
      .hi      (HI),
      .max_amp (shadow_amp[gi*DW +: DW]),
      .max_idx (shadow_idx[gi*CNT_W +: CNT_W])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      amp_hold_reg <= '0;
      idx_hold_reg <= '0;
    end else if (done) begin
      amp_hold_reg <= shadow_amp;
      idx_hold_reg <= shadow_idx;
    end
  end

  // During PUBLISH the settled shadows are presented directly so the new
  // results coincide with done; the hold registers keep them afterwards.
  assign amp_bus = done ? shadow_amp : amp_hold_reg;
  assign idx_bus = done ? shadow_idx : idx_hold_reg;

endmodule

// File: tb/tb_harmonic_capture.sv
// Scoreboard bench for harmonic_capture: expected results are queued when a
// frame's last window bin is driven and checked when done pulses.
module tb_harmonic_capture;

  localparam int DW     = 24;
  localparam int NUM_H  = 5;
  localparam int BIN0   = 24;
  localparam int STRIDE = 48;
  localparam int WIN    = 2;
  localparam int CNT_W  = 10;
  localparam int LAST   = BIN0 + (NUM_H - 1) * STRIDE + WIN;

  typedef struct {
    logic [NUM_H*DW-1:0]    amp;
    logic [NUM_H*CNT_W-1:0] idx;
    int                     cyc;
  } exp_t;

  logic                   clk;
  logic                   rst_n;
  logic                   source_sop;
  logic                   source_valid;
  logic [DW-1:0]          amp;
  logic [NUM_H*DW-1:0]    amp_bus;
  logic [NUM_H*CNT_W-1:0] idx_bus;
  logic                   done;
  logic                   busy;

  int   vectors;
  int   miscompares;
  int   cyc;
  exp_t sb[$];
  exp_t last_pub;
  logic [DW-1:0] frame_amp [0:1023];

  harmonic_capture #(
    .DW(DW), .NUM_H(NUM_H), .BIN0(BIN0), .STRIDE(STRIDE), .WIN(WIN), .CNT_W(CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .source_sop   (source_sop),
    .source_valid (source_valid),
    .amp          (amp),
    .amp_bus      (amp_bus),
    .idx_bus      (idx_bus),
    .done         (done),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1);
  end

  // Reference: earliest strict maximum over each window.
  function automatic exp_t model(input int done_cyc);
    exp_t e;
    int c;
    int bi;
    logic [DW-1:0] best;
    e.amp = '0;
    e.idx = '0;
    e.cyc = done_cyc;
    for (int h = 0; h < NUM_H; h++) begin
      c    = BIN0 + h * STRIDE;
      bi   = c - WIN;
      best = frame_amp[c - WIN];
      for (int b = c - WIN + 1; b <= c + WIN; b++) begin
        if (frame_amp[b] > best) begin
          best = frame_amp[b];
          bi   = b;
        end
      end
      e.amp[h*DW +: DW]       = best;
      e.idx[h*CNT_W +: CNT_W] = bi[CNT_W-1:0];
    end
    return e;
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (done === 1'b1) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_done: done=1 at cyc %0d, required no done", cyc);
      end else begin
        e = sb.pop_front();
        last_pub = e;
        if (cyc != e.cyc) begin
          miscompares++;
          $display("FAIL done_latency: done at cyc %0d, required cyc %0d", cyc, e.cyc);
        end
        vectors++;
        if (amp_bus !== e.amp) begin
          miscompares++;
          $display("FAIL amp_bus: got %h, required %h", amp_bus, e.amp);
        end
        vectors++;
        if (idx_bus !== e.idx) begin
          miscompares++;
          $display("FAIL idx_bus: got %h, required %h", idx_bus, e.idx);
        end
      end
    end
  end

  task automatic fill_ramp();
    for (int b = 0; b < 1024; b++) frame_amp[b] = DW'(b * 10);
  endtask

  task automatic fill_zero();
    for (int b = 0; b < 1024; b++) frame_amp[b] = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      source_valid = 1'b0;
      source_sop   = 1'b0;
    end
  endtask

  // Drives bins 0..n-1; with toggle, each accepted bin is followed by an
  // invalid cycle carrying a sop that must be ignored.
  task automatic send_frame(input int n, input bit toggle);
    for (int b = 0; b < n; b++) begin
      @(posedge clk); #1;
      source_valid = 1'b1;
      source_sop   = (b == 0);
      amp          = frame_amp[b];
      if (b == LAST) sb.push_back(model(cyc + 1));
      if (toggle) begin
        @(posedge clk); #1;
        source_valid = 1'b0;
        source_sop   = 1'b1;
        amp          = '1;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    source_valid = 1'b1;
    source_sop   = 1'b1;
    amp          = 24'h777777;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (amp_bus !== '0 || idx_bus !== '0) begin
      miscompares++;
      $display("FAIL reset_bus: amp_bus=%h idx_bus=%h, required 0", amp_bus, idx_bus);
    end
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_flags: done=%b busy=%b, required 0 0", done, busy);
    end
    source_valid = 1'b0;
    source_sop   = 1'b0;
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_basic();
    fill_ramp();
    for (int h = 0; h < NUM_H; h++) frame_amp[BIN0 + h * STRIDE] = DW'(24'hFFFFF0 + h);
    send_frame(LAST + 1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (i == 1) begin
        vectors++;
        if (busy !== 1'b0) begin
          miscompares++;
          $display("FAIL basic_busy_after: busy=%b, required 0", busy);
        end
      end
    end
    idle(4);
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL basic_drain: %0d results pending, required 0", sb.size());
      sb.delete();
    end
    for (int h = 0; h < NUM_H; h++) begin
      vectors++;
      if (amp_bus[h*DW +: DW] !== DW'(24'hFFFFF0 + h) ||
          idx_bus[h*CNT_W +: CNT_W] !== CNT_W'(BIN0 + h * STRIDE)) begin
        miscompares++;
        $display("FAIL basic_h%0d: amp=%h idx=%0d, required amp=%h idx=%0d", h,
                 amp_bus[h*DW +: DW], idx_bus[h*CNT_W +: CNT_W], 24'hFFFFF0 + h,
                 BIN0 + h * STRIDE);
      end
    end
  endtask

  task automatic test_window_edges();
    fill_ramp();
    frame_amp[70]  = 24'hABCDEF;
    frame_amp[218] = 24'h654321;
    frame_amp[69]  = 24'hFFFFFF;
    frame_amp[219] = 24'hFFFFFF;
    send_frame(230, 1'b0);
    idle(4);
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL edges_drain: %0d results pending, required 0", sb.size());
      sb.delete();
    end
    vectors++;
    if (idx_bus[1*CNT_W +: CNT_W] !== 10'd70 || amp_bus[1*DW +: DW] !== 24'hABCDEF) begin
      miscompares++;
      $display("FAIL edges_low: idx=%0d amp=%h, required idx=70 amp=abcdef",
               idx_bus[1*CNT_W +: CNT_W], amp_bus[1*DW +: DW]);
    end
    vectors++;
    if (idx_bus[4*CNT_W +: CNT_W] !== 10'd218 || amp_bus[4*DW +: DW] !== 24'h654321) begin
      miscompares++;
      $display("FAIL edges_high: idx=%0d amp=%h, required idx=218 amp=654321",
               idx_bus[4*CNT_W +: CNT_W], amp_bus[4*DW +: DW]);
    end
  endtask

  task automatic test_tie();
    fill_zero();
    frame_amp[22] = 24'h123456;
    frame_amp[25] = 24'h123456;
    send_frame(LAST + 1, 1'b0);
    idle(4);
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL tie_drain: %0d results pending, required 0", sb.size());
      sb.delete();
    end
    vectors++;
    if (idx_bus[0 +: CNT_W] !== 10'd22 || amp_bus[0 +: DW] !== 24'h123456) begin
      miscompares++;
      $display("FAIL tie_earliest: idx=%0d amp=%h, required idx=22 amp=123456",
               idx_bus[0 +: CNT_W], amp_bus[0 +: DW]);
    end
  endtask

  task automatic test_valid_toggle();
    fill_ramp();
    for (int h = 0; h < NUM_H; h++) frame_amp[BIN0 + h * STRIDE] = DW'(24'hFFFFF0 + h);
    send_frame(LAST + 1, 1'b1);
    idle(4);
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL toggle_drain: %0d results pending, required 0", sb.size());
      sb.delete();
    end
    vectors++;
    if (idx_bus[3*CNT_W +: CNT_W] !== 10'd168 || amp_bus[3*DW +: DW] !== 24'hFFFFF3) begin
      miscompares++;
      $display("FAIL toggle_h3: idx=%0d amp=%h, required idx=168 amp=fffff3",
               idx_bus[3*CNT_W +: CNT_W], amp_bus[3*DW +: DW]);
    end
  endtask

  task automatic test_restart();
    for (int b = 0; b < 1024; b++) frame_amp[b] = DW'(24'h500000 + b);
    send_frame(100, 1'b0);
    @(negedge clk);
    vectors++;
    if (amp_bus !== last_pub.amp || idx_bus !== last_pub.idx) begin
      miscompares++;
      $display("FAIL restart_hold: amp_bus=%h, required %h", amp_bus, last_pub.amp);
    end
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL restart_busy: busy=%b, required 1", busy);
    end
    fill_ramp();
    send_frame(LAST + 1, 1'b0);
    idle(4);
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL restart_drain: %0d results pending, required 0", sb.size());
      sb.delete();
    end
    vectors++;
    if (amp_bus[0 +: DW] !== 24'd260 || idx_bus[0 +: CNT_W] !== 10'd26) begin
      miscompares++;
      $display("FAIL restart_b_h0: amp=%0d idx=%0d, required amp=260 idx=26",
               amp_bus[0 +: DW], idx_bus[0 +: CNT_W]);
    end
  endtask

  task automatic test_back_to_back();
    fill_ramp();
    for (int h = 0; h < NUM_H; h++) frame_amp[BIN0 + h * STRIDE + 1] = DW'(24'h300000 + h);
    send_frame(LAST + 1, 1'b0);
    fill_ramp();
    for (int h = 0; h < NUM_H; h++) frame_amp[BIN0 + h * STRIDE - 1] = DW'(24'h400000 + h);
    send_frame(LAST + 1, 1'b0);
    idle(4);
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL b2b_drain: %0d results pending, required 0", sb.size());
      sb.delete();
    end
    for (int h = 0; h < NUM_H; h++) begin
      vectors++;
      if (idx_bus[h*CNT_W +: CNT_W] !== CNT_W'(BIN0 + h * STRIDE - 1)) begin
        miscompares++;
        $display("FAIL b2b_h%0d: idx=%0d, required %0d", h, idx_bus[h*CNT_W +: CNT_W],
                 BIN0 + h * STRIDE - 1);
      end
    end
  endtask

  task automatic test_reset_mid();
    fill_ramp();
    send_frame(130, 1'b0);
    @(posedge clk); #1;
    rst_n        = 1'b0;
    source_valid = 1'b1;
    source_sop   = 1'b0;
    amp          = frame_amp[130];
    @(posedge clk); #1;
    rst_n        = 1'b1;
    source_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (amp_bus !== '0 || idx_bus !== '0) begin
      miscompares++;
      $display("FAIL midreset_bus: amp_bus=%h idx_bus=%h, required 0", amp_bus, idx_bus);
    end
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_flags: busy=%b done=%b, required 0 0", busy, done);
    end
    idle(100);
    for (int h = 0; h < NUM_H; h++) frame_amp[BIN0 + h * STRIDE] = DW'(24'hFFFFF0 + h);
    send_frame(LAST + 1, 1'b0);
    idle(4);
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL midreset_drain: %0d results pending, required 0", sb.size());
      sb.delete();
    end
    vectors++;
    if (idx_bus[2*CNT_W +: CNT_W] !== 10'd120 || amp_bus[2*DW +: DW] !== 24'hFFFFF2) begin
      miscompares++;
      $display("FAIL midreset_recap: idx=%0d amp=%h, required idx=120 amp=fffff2",
               idx_bus[2*CNT_W +: CNT_W], amp_bus[2*DW +: DW]);
    end
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    rst_n        = 1'b0;
    source_sop   = 1'b0;
    source_valid = 1'b0;
    amp          = '0;
    last_pub.amp = '0;
    last_pub.idx = '0;
    last_pub.cyc = 0;
    test_reset();
    test_basic();
    test_window_edges();
    test_tie();
    test_valid_toggle();
    test_restart();
    test_back_to_back();
    test_reset_mid();
    idle(5);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
